// File: rtl/int_event_capture.sv
// +--------------------------------------------------------------------------+
// | int_event_capture: rising-edge interrupt capture into a timestamped FIFO  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module int_event_capture #(
  parameter int WIDTH = 56,
  parameter int DEPTH = 8,
  parameter int TS_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic [WIDTH-1:0]         interrupt,
  input  logic [WIDTH-1:0]         int_mask,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [$clog2(WIDTH)-1:0] evt_idx,
  output logic [TS_W-1:0]          evt_ts,
  output logic                     lost_flag,
  input  logic                     lost_clr
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] int_q;
  logic             armed;
  logic [TS_W-1:0]  ts_cnt;
  logic [WIDTH-1:0] pending;
  logic [TS_W-1:0]  line_ts [WIDTH];

  logic [IDX_W-1:0] fifo_idx [DEPTH];
  logic [TS_W-1:0]  fifo_ts  [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;

  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] clr_vec;
  logic             sel_any;
  logic [IDX_W-1:0] sel_idx;
  logic [TS_W-1:0]  sel_ts;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             pop;
  logic             loss;

  // armed stays low for the first cycle after reset so a line already high is absorbed into int_q
  assign rise = interrupt & ~int_q & int_mask & {WIDTH{armed}};

  // Descending scan leaves the lowest-index pending line selected
  always_comb begin
    sel_any = 1'b0;
    sel_idx = '0;
    sel_ts  = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending[i]) begin
        sel_any = 1'b1;
        sel_idx = IDX_W'(i);
        sel_ts  = line_ts[i];
      end
    end
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop        = evt_valid & evt_ready;
  assign push       = sel_any & (~fifo_full | pop);

  always_comb begin
    clr_vec = '0;
    for (int i = 0; i < WIDTH; i++) begin
      clr_vec[i] = push && (sel_idx == IDX_W'(i));
    end
  end

  assign loss = |(rise & pending & ~clr_vec);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      int_q     <= '0;
      armed     <= 1'b0;
      ts_cnt    <= '0;
      pending   <= '0;
      lost_flag <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        line_ts[i] <= '0;
      end
    end else begin
      int_q  <= interrupt;
      armed  <= 1'b1;
      ts_cnt <= ts_cnt + TS_W'(1);
      for (int i = 0; i < WIDTH; i++) begin
        // An edge landing on the cycle its line is pushed starts a fresh event
        if (rise[i] && (!pending[i] || clr_vec[i])) begin
          pending[i] <= 1'b1;
          line_ts[i] <= ts_cnt;
        end else if (clr_vec[i]) begin
          pending[i] <= 1'b0;
        end
      end
      if (loss) begin
        lost_flag <= 1'b1;
      end else if (lost_clr) begin
        lost_flag <= 1'b0;
      end
      if (push) begin
        wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_idx[wr_ptr[PTR_W-1:0]] <= sel_idx;
      fifo_ts[wr_ptr[PTR_W-1:0]]  <= sel_ts;
    end
  end

  assign evt_valid = ~fifo_empty;
  assign evt_idx   = evt_valid ? fifo_idx[rd_ptr[PTR_W-1:0]] : '0;
  assign evt_ts    = evt_valid ? fifo_ts[rd_ptr[PTR_W-1:0]]  : '0;

endmodule

`default_nettype wire

// File: tb/tb_int_event_capture.sv
// +--------------------------------------------------------------------------+
// | tb_int_event_capture: directed + random bench with a queue-based model    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_int_event_capture;

  localparam int WIDTH = 56;
  localparam int DEPTH = 8;

  logic              clk = 1'b0;
  logic              rst_b;
  logic [WIDTH-1:0]  interrupt;
  logic [WIDTH-1:0]  int_mask;
  logic              evt_ready;
  logic              lost_clr;

  logic              evt_valid,   evt_valid_s;
  logic [5:0]        evt_idx,     evt_idx_s;
  logic [31:0]       evt_ts;
  logic [3:0]        evt_ts_s;
  logic              lost_flag,   lost_flag_s;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state
  logic [WIDTH-1:0]  m_intq;
  bit                m_armed;
  logic [31:0]       m_ts;
  logic [WIDTH-1:0]  m_pend;
  logic [31:0]       m_pts [WIDTH];
  int                q_idx [$];
  logic [31:0]       q_ts  [$];
  bit                m_lost;

  int_event_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TS_W(32)) u_dut (
    .clk(clk), .rst_b(rst_b), .interrupt(interrupt), .int_mask(int_mask),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_idx(evt_idx),
    .evt_ts(evt_ts), .lost_flag(lost_flag), .lost_clr(lost_clr)
  );

  int_event_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TS_W(4)) u_dut_s (
    .clk(clk), .rst_b(rst_b), .interrupt(interrupt), .int_mask(int_mask),
    .evt_valid(evt_valid_s), .evt_ready(evt_ready), .evt_idx(evt_idx_s),
    .evt_ts(evt_ts_s), .lost_flag(lost_flag_s), .lost_clr(lost_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_intq  = '0;
    m_armed = 0;
    m_ts    = '0;
    m_pend  = '0;
    for (int i = 0; i < WIDTH; i++) m_pts[i] = '0;
    q_idx.delete();
    q_ts.delete();
    m_lost  = 0;
  endtask

  task automatic compare();
    logic [31:0] hts;
    chk("evt_valid",   evt_valid,   q_idx.size() > 0);
    chk("evt_valid_s", evt_valid_s, q_idx.size() > 0);
    if (q_idx.size() > 0) begin
      hts = q_ts[0];
      chk("evt_idx",   evt_idx,   q_idx[0]);
      chk("evt_idx_s", evt_idx_s, q_idx[0]);
      chk("evt_ts",    evt_ts,    hts);
      chk("evt_ts_s",  evt_ts_s,  hts[3:0]);
    end else begin
      chk("evt_idx_idle", evt_idx, 0);
      chk("evt_ts_idle",  evt_ts,  0);
    end
    chk("lost_flag",   lost_flag,   m_lost);
    chk("lost_flag_s", lost_flag_s, m_lost);
  endtask

  // One clock: model the cycle from the rules, then compare after the edge
  task automatic step();
    int               sel;
    bit               pop, push, loss;
    logic [WIDTH-1:0] rise;
    pop  = (q_idx.size() > 0) && evt_ready;
    rise = interrupt & ~m_intq & int_mask & {WIDTH{m_armed}};
    sel  = -1;
    for (int i = 0; i < WIDTH; i++) if (m_pend[i] && sel < 0) sel = i;
    push = (sel >= 0) && (q_idx.size() < DEPTH || pop);
    if (pop) begin
      void'(q_idx.pop_front());
      void'(q_ts.pop_front());
    end
    if (push) begin
      q_idx.push_back(sel);
      q_ts.push_back(m_pts[sel]);
      m_pend[sel] = 1'b0;
    end
    loss = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (rise[i]) begin
        if (m_pend[i]) loss = 1;
        else begin
          m_pend[i] = 1'b1;
          m_pts[i]  = m_ts;
        end
      end
    end
    m_lost  = loss ? 1'b1 : (lost_clr ? 1'b0 : m_lost);
    m_intq  = interrupt;
    m_armed = 1;
    m_ts    = m_ts + 32'd1;
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    #1;
    model_reset();
    compare();
    @(posedge clk);
    #1;
    compare();
    rst_b = 1'b1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    logic [31:0] t0;
    rst_b     = 1'b0;
    interrupt = '0;
    int_mask  = '1;
    evt_ready = 1'b0;
    lost_clr  = 1'b0;
    model_reset();
    #12;
    compare();
    @(posedge clk); #1;
    rst_b = 1'b1;

    // Single edge on line 5 at ts=100
    while (m_ts != 32'd100) step();
    interrupt[5] = 1'b1;
    steps(2);
    chk("single_valid", evt_valid, 1);
    chk("single_idx",   evt_idx,   5);
    chk("single_ts",    evt_ts,    100);
    evt_ready = 1'b1;
    step();
    chk("single_pop", evt_valid, 0);
    evt_ready = 1'b0;
    interrupt = '0;
    steps(2);

    // Simultaneous edges drain in index order
    interrupt[3] = 1'b1; interrupt[0] = 1'b1; interrupt[40] = 1'b1;
    t0 = m_ts;
    steps(2);
    evt_ready = 1'b1;
    chk("sim_idx0", evt_idx, 0);
    chk("sim_ts0",  evt_ts,  t0);
    step();
    chk("sim_idx3", evt_idx, 3);
    step();
    chk("sim_idx40", evt_idx, 40);
    chk("sim_ts40",  evt_ts,  t0);
    step();
    chk("sim_empty", evt_valid, 0);
    evt_ready = 1'b0;
    interrupt = '0;
    steps(2);

    // Full FIFO, then a double pulse on a held line
    interrupt[9:0] = '1;
    steps(12);
    chk("full_lost", lost_flag, 0);
    chk("full_head", evt_idx,   0);
    interrupt[12] = 1'b1; step();
    interrupt[12] = 1'b0; step();
    interrupt[12] = 1'b1; steps(2);
    chk("loss_flag", lost_flag, 1);
    evt_ready = 1'b1;
    steps(16);
    chk("drain_empty", evt_valid, 0);
    lost_clr = 1'b1; step();
    lost_clr = 1'b0;
    chk("lost_cleared", lost_flag, 0);
    evt_ready = 1'b0;
    interrupt = '0;
    steps(2);

    // Masked line, line high across reset release, reset with queued events
    int_mask[7] = 1'b0;
    interrupt[7] = 1'b1; step();
    interrupt[7] = 1'b0; steps(4);
    chk("mask_none", evt_valid, 0);
    int_mask = '1;
    interrupt[2] = 1'b1;
    do_reset();
    steps(4);
    chk("rst_high_none", evt_valid, 0);
    interrupt = '0;
    step();
    interrupt[23:20] = '1;
    steps(6);
    chk("queued4", evt_valid, 1);
    interrupt = '0;
    do_reset();
    chk("rst_flush", evt_valid, 0);
    step();
    interrupt[30] = 1'b1;
    steps(2);
    chk("ts_restart", evt_ts, 1);
    evt_ready = 1'b1;
    interrupt = '0;
    steps(4);

    // Timestamp wrap on the 4-bit instance
    evt_ready = 1'b0;
    while (m_ts[3:0] != 4'd15) step();
    interrupt[1] = 1'b1; step();
    interrupt[2] = 1'b1; steps(3);
    chk("wrap_ts15", evt_ts_s, 15);
    evt_ready = 1'b1;
    step();
    chk("wrap_ts0", evt_ts_s, 0);
    interrupt = '0;
    steps(4);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      interrupt ^= {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom}
                 & {$urandom, $urandom};
      if ($urandom_range(0, 49) == 0) int_mask = {$urandom, $urandom} | {$urandom, $urandom};
      evt_ready = ($urandom_range(0, 3) != 0) ? (c % 400 > 120) : ($urandom_range(0, 1) == 1);
      lost_clr  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 799) == 0) do_reset();
      else step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/int_event_capture.md
INT_EVENT_CAPTURE -- requirements
Module: int_event_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 56, number of interrupt lines monitored.
REQ-002 SHALL have parameter DEPTH, default 8, event FIFO entries (power of two, >=2).
REQ-003 SHALL have parameter TS_W, default 32, timestamp width.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst_b  input  1  asynchronous active-low reset.
REQ-006 SHALL have port interrupt  input  WIDTH  level interrupt vector, synchronous to clk.
REQ-007 SHALL have port int_mask  input  WIDTH  1 = line enabled for capture.
REQ-008 SHALL have port evt_valid  output  1  FIFO head holds an event.
REQ-009 SHALL have port evt_ready  input  1  consumer accepts head when evt_valid=1.
REQ-010 SHALL have port evt_idx  output  $clog2(WIDTH)  line number of head event.
REQ-011 SHALL have port evt_ts  output  TS_W  timestamp of head event.
REQ-012 SHALL have port lost_flag  output  1  sticky: at least one edge dropped.
REQ-013 SHALL have port lost_clr  input  1  synchronous clear of lost_flag.

Function
REQ-014 SHALL register interrupt into int_q every cycle; edge[i] = interrupt[i] & ~int_q[i] & int_mask[i].
REQ-015 SHALL keep free-running counter ts_cnt, +1 per cycle, wrapping from all-ones to 0.
REQ-016 SHALL set pending[i] on edge[i]; timestamp stored per line = ts_cnt in the edge cycle.
REQ-017 SHALL each cycle select the lowest-index set pending bit and, if FIFO not full, push {idx, stored ts} and clear that pending bit in the same cycle.
REQ-018 SHALL push at most one event per cycle; other pending bits wait.
REQ-019 SHALL, when edge[i] occurs while pending[i]=1 and pending[i] is not being cleared that cycle, keep the original timestamp and set lost_flag.
REQ-020 SHALL, when edge[i] coincides with the cycle pending[i] is pushed, re-set pending[i] with the new timestamp (no loss).
REQ-021 SHALL, when FIFO is full, hold pending bits (no push, no loss unless REQ-019 applies).
REQ-022 SHALL pop the head when evt_valid & evt_ready; push and pop in the same cycle SHALL both occur, including when full (pop frees the slot used by the push).
REQ-023 SHALL present head fields combinationally from FIFO storage; evt_idx/evt_ts SHALL be stable while evt_valid=1 and evt_ready=0.
REQ-024 SHALL have minimum latency 2 cycles: edge in interrupt at cycle N -> evt_valid=1 at cycle N+2 (pending at N+1, FIFO at N+2).
REQ-025 SHALL give lost_clr priority lower than a simultaneous new loss (flag stays 1).
REQ-026 SHALL ignore lines with int_mask=0 for edge detection; clearing a mask bit SHALL NOT clear an already set pending bit.
REQ-027 SHALL treat evt_ready while evt_valid=0 as no-op.

Reset
REQ-028 SHALL on rst_b=0 asynchronously clear int_q, pending, stored timestamps, ts_cnt, FIFO pointers, lost_flag; evt_valid=0, evt_idx=0, evt_ts=0.
REQ-029 SHALL, on rst_b deassertion with a line already high, not report an edge for it (int_q starts 0 but first cycle after reset SHALL load int_q without capture).
REQ-030 SHALL discard all queued and pending events on reset asserted mid-operation.

Verification
REQ-031 Single edge: mask all-ones, interrupt[5] 0->1 at cycle with ts_cnt=100 -> evt_valid at +2 cycles, evt_idx=5, evt_ts=100; pop -> evt_valid=0.
REQ-032 Simultaneous edges on lines 3, 0, 40 same cycle ts=T -> events popped in order idx 0,3,40, all evt_ts=T, on consecutive cycles with evt_ready=1.
REQ-033 Full FIFO: evt_ready=0, edges on lines 0..9 -> 8 entries queued, lines 8,9 stay pending, lost_flag=0; then raise evt_ready -> all 10 delivered in index order.
REQ-034 Loss: evt_ready=0, FIFO full, line 12 pulses twice -> lost_flag=1, one event idx 12 with first timestamp; lost_clr -> lost_flag=0.
REQ-035 Mask/reset: line 7 masked pulses -> no event; line 2 high across rst_b release -> no event; rst_b pulse with 4 queued -> evt_valid=0, ts_cnt restarts at 0.
REQ-036 Timestamp wrap: TS_W=4, edge at ts_cnt=15 and next at 0 -> evt_ts 15 then 0.
